// File: rtl/vga_image_scanner_pkg.sv
// +----------------------------------------------------------------------+
// | vga_image_scanner_pkg                                                |
// | Shared 640x480@60 VGA timing constants and sizing helper.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_image_scanner_pkg;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int VGA_H_TOT        = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT        = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_image_scanner_timing.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen                                                       |
// | Pixel-tick divider, h/v raster counters and raw sync/de decode.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import vga_image_scanner_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP,
  parameter int H_W     = cnt_width(H_VIS + H_FP + H_SYNC + H_BP),
  parameter int V_W     = cnt_width(V_VIS + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic           tick,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic [H_W-1:0] h_adv,
  output logic [V_W-1:0] v_adv,
  output logic           line_end,
  output logic           frame_end,
  output logic           hsync_raw,
  output logic           vsync_raw,
  output logic           de_raw
);

  localparam int c_div_w = cnt_width(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
  localparam logic [H_W-1:0] c_h_last     = H_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_W-1:0] c_v_last     = V_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [H_W-1:0] c_h_vis      = H_W'(H_VIS);
  localparam logic [V_W-1:0] c_v_vis      = V_W'(V_VIS);
  localparam logic [H_W-1:0] c_hs_start   = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0] c_hs_end     = H_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_W-1:0] c_vs_start   = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0] c_vs_end     = V_W'(V_VIS + V_FP + V_SYNC);

  logic [c_div_w-1:0] r_div;
  logic [H_W-1:0]     r_h_cnt;
  logic [V_W-1:0]     r_v_cnt;

  assign tick      = en && (r_div == c_div_max);
  assign line_end  = (r_h_cnt == c_h_last);
  assign frame_end = line_end && (r_v_cnt == c_v_last);
  assign h_adv     = line_end ? '0 : r_h_cnt + 1'b1;
  assign v_adv     = line_end ? (frame_end ? '0 : r_v_cnt + 1'b1) : r_v_cnt;
  assign h_cnt     = r_h_cnt;
  assign v_cnt     = r_v_cnt;

  assign hsync_raw = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
  assign vsync_raw = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
  assign de_raw    = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en) begin
      r_div <= tick ? '0 : r_div + 1'b1;
      if (tick) begin
        r_h_cnt <= h_adv;
        r_v_cnt <= v_adv;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_image_scanner.sv
// +----------------------------------------------------------------------+
// | vga_image_scanner                                                    |
// | VGA raster scan of the data-memory image with aligned pixel output.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_image_scanner
  import vga_image_scanner_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = VGA_H_VIS,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_VIS    = VGA_V_VIS,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int IMG_BASE = 40,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] vga_addr,
  input  logic [7:0]        img_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        pixel,
  output logic              frame_start
);

  localparam int c_h_w = cnt_width(H_VIS + H_FP + H_SYNC + H_BP);
  localparam int c_v_w = cnt_width(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(IMG_BASE);
  localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(IMG_W);
  localparam logic [c_h_w-1:0]  c_win_w    = c_h_w'(IMG_W);
  localparam logic [c_v_w-1:0]  c_win_h    = c_v_w'(IMG_H);
  localparam logic [c_v_w-1:0]  c_row_last = c_v_w'(IMG_H - 1);

  logic             w_tick;
  logic [c_h_w-1:0] w_h_cnt;
  logic [c_h_w-1:0] w_h_adv;
  logic [c_v_w-1:0] w_v_cnt;
  logic [c_v_w-1:0] w_v_adv;
  logic             w_line_end;
  logic             w_frame_end;
  logic             w_hsync_raw;
  logic             w_vsync_raw;
  logic             w_de_raw;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .H_W     (c_h_w),
    .V_W     (c_v_w)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tick      (w_tick),
    .h_cnt     (w_h_cnt),
    .v_cnt     (w_v_cnt),
    .h_adv     (w_h_adv),
    .v_adv     (w_v_adv),
    .line_end  (w_line_end),
    .frame_end (w_frame_end),
    .hsync_raw (w_hsync_raw),
    .vsync_raw (w_vsync_raw),
    .de_raw    (w_de_raw)
  );

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] w_row_base_adv;
  logic [ADDR_W-1:0] w_addr_adv;
  logic              w_win_cur;
  logic              w_win_adv;
  logic              r_frame_pend;

  assign w_win_cur = (w_h_cnt < c_win_w) && (w_v_cnt < c_win_h);
  assign w_win_adv = (w_h_adv < c_win_w) && (w_v_adv < c_win_h);

  // Row base must already reflect the line being entered, so the address
  // loaded at a line-wrap tick points into the new row.
  always_comb begin
    w_row_base_adv = r_row_base;
    if (w_frame_end) begin
      w_row_base_adv = c_base;
    end else if (w_line_end && (w_v_cnt < c_row_last)) begin
      w_row_base_adv = r_row_base + c_row_step;
    end
  end

  assign w_addr_adv = w_win_adv ? (w_row_base_adv + ADDR_W'(w_h_adv)) : c_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base   <= c_base;
      vga_addr     <= c_base;
      pixel        <= 8'd0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      de           <= 1'b0;
      r_frame_pend <= 1'b0;
    end else if (w_tick) begin
      r_row_base   <= w_row_base_adv;
      vga_addr     <= w_addr_adv;
      pixel        <= w_win_cur ? img_data : 8'd0;
      hsync        <= w_hsync_raw;
      vsync        <= w_vsync_raw;
      de           <= w_de_raw;
      r_frame_pend <= w_frame_end;
    end
  end

  // Pulse only for a (0,0) reached through a frame wrap, never for the
  // position the counters sit at straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_tick && r_frame_pend;
    end
  end

endmodule

`default_nettype wire

// File: doc/vga_image_scanner.md
# vga_image_scanner

Raster scanner on the read side of the data memory's VGA port. Generates 640x480@60 VGA timing, walks the image region of data memory pixel by pixel through the 19-bit VGA address port, and presents the returned 8-bit grayscale sample aligned with hsync/vsync/data-enable for the video DAC. Pixels outside the image window are driven black.

## Interface

Parameters:

- CLK_DIV, 2, clk cycles per pixel tick (50 MHz clk gives a 25 MHz pixel rate)
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in lines
- IMG_BASE, 40, byte address of image pixel (0,0) in data memory
- ADDR_W, 19, width of the VGA address

Ports:

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable; low freezes divider, counters and outputs
- vga_addr  out  ADDR_W  address to the memory VGA port
- img_data  in  8  byte returned for vga_addr (combinational read, valid the same cycle)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  high during the visible 640x480 area
- pixel  out  8  grayscale sample; 0 outside the image window or when de is low
- frame_start  out  1  one-clk pulse at the tick that outputs pixel (0,0)

## Operation

- Divider counts 0..CLK_DIV-1 while en is high. A tick occurs when it reaches CLK_DIV-1 and it then wraps to 0.
- h_cnt runs 0..H_TOT-1 (H_TOT = 800) and advances on every tick.
- v_cnt runs 0..V_TOT-1 (V_TOT = 525) and advances when h_cnt wraps. Both counters wrap to 0 together at end of frame.
- Raw sync decode: hsync low for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC). vsync uses the same form on v_cnt.
- Raw de = (h_cnt < H_VIS) && (v_cnt < V_VIS).
- Image window: h_cnt < IMG_W && v_cnt < IMG_H, placed at the top-left of the screen.
- Address generation uses no multiplier:
  - row_base register resets to IMG_BASE.
  - row_base += IMG_W when v advances while v_cnt < IMG_H-1.
  - row_base returns to IMG_BASE at frame wrap.
  - vga_addr = row_base + h_cnt inside the window. Outside the window vga_addr holds IMG_BASE.
- vga_addr is a register. It is loaded at each tick with the address for the counter values that are taking effect at that tick.
- Output stage, on the following tick:
  - pixel <= img_data if that position was in the window, else 0.
  - hsync, vsync and de are delayed one tick so they stay aligned with pixel.
- All arithmetic is unsigned, ADDR_W bits wide. IMG_BASE + IMG_W*IMG_H must be ≤ 2^ADDR_W; there is no wrap handling.

## Timing

- Reset values: divider 0, h_cnt 0, v_cnt 0, row_base IMG_BASE, vga_addr IMG_BASE, hsync 1, vsync 1, de 0, pixel 0, frame_start 0.
- Latency: one pixel tick from vga_addr to pixel.
- After rst_n rises with en high:
  - The first tick loads the address for (h=1,v=0).
  - pixel for (0,0) appears after the tick that follows h=0 at the frame wrap.
  - frame_start pulses for exactly one clk at that tick, in every frame.
- Line period is 800 ticks; frame period is 525 lines = 420000 ticks.
- en low mid-line: every register holds its value. The scan resumes exactly where it stopped. frame_start is not re-asserted.
- rst_n asserted mid-frame: all registers take reset values immediately (asynchronously). The scan restarts at (0,0).
- At the last line of the image, v advance and h wrap occur in the same tick. row_base must then hold, not increment.

## Structure

- Shared package holds the VGA timing constants and the derived H_TOT, V_TOT, sync start and sync end values. The team's other video blocks reuse it.
- One natural sub-module is vga_timing_gen (divider, h/v counters, raw sync and de decode, tick output). The top adds address generation and the output alignment stage.

## Test plan

- Reset then en=1, CLK_DIV=2 -> first hsync low at h=656+1 tick (delayed). hsync low for 96 ticks, line period exactly 1600 clk. vsync low for 2 lines starting at line 490.
- Frame scan with memory model (byte = address[7:0]) -> pixel at (0,0)=0x28, (31,0)=0x47, (0,1)=0x48, (31,31)=0x27 (addr 1063). pixel=0 at (32,0) and (0,32).
- Address trace -> vga_addr=IMG_BASE outside the window. row_base is not incremented past line 31. The address sequence repeats identically in frame 2.
- en dropped for 100 clk at h=300 -> every output frozen for that time. The line completes 100 clk late and no ticks are lost.
- rst_n pulsed low at line 200 -> outputs take reset values the same cycle. The next frame_start comes 420000 ticks after release plus one line-0 tick.
- CLK_DIV=1, IMG_W=4, IMG_H=2 -> pixel rate equals clk. Only 8 nonzero pixels per frame, at addresses 40..47.
